decode_stage: RTL

//  Fetch->decode pipeline stage of the RV32I core. Accepts 32-bit instructions from fetch via valid/ready,

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/instr_class_dec.sv | 23 ++
 rtl/decode_stage.sv | 75 +++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcode, immediate-type and decoded-beat definitions
package rv32_pkg;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_B    = 3'd1,
        IMM_S    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        imm_type_e   imm_type;
        logic        illegal;
    } beat_t;
endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: combinational opcode classifier giving immediate type and illegal flag
module instr_class_dec
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output imm_type_e   imm_type,
    output logic        illegal
);
    // Matching the full 7-bit opcode also rejects instr[1:0] != 2'b11.
    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: imm_type = IMM_I;
            OPC_STORE:                                                 imm_type = IMM_S;
            OPC_BRANCH:                                                imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:                                        imm_type = IMM_U;
            OPC_JAL:                                                   imm_type = IMM_J;
            OPC_OP:                                                    imm_type = IMM_NONE;
            default:                                                   illegal  = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch->decode register stage with 2-entry skid buffer and opcode classification
module decode_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [24:0]     out_imm_bits,
    output logic [2:0]      out_imm_type,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [6:0]      out_opcode,
    output logic            out_illegal
);
    beat_t     main_q, skid_q, new_beat;
    logic      main_v, skid_v, accept;
    imm_type_e dec_type;
    logic      dec_illegal;

    instr_class_dec u_dec (
        .instr    (in_instr),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign accept   = in_valid && in_ready;
    assign new_beat = '{pc: in_pc, instr: in_instr, imm_type: dec_type, illegal: dec_illegal};

    // Main drains first; skid only fills when main is held, so in_ready never depends on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
            if (!rst_n) begin
                main_q <= '{pc: RESET_PC, instr: '0, imm_type: IMM_I, illegal: 1'b0};
                skid_q <= '{pc: '0, instr: '0, imm_type: IMM_I, illegal: 1'b0};
            end
        end else if (!main_v || out_ready) begin
            main_v   <= skid_v || accept;
            main_q   <= skid_v ? skid_q : accept ? new_beat : main_q;
            skid_v   <= 1'b0;
            in_ready <= 1'b1;
        end else if (accept) begin
            skid_q   <= new_beat;
            skid_v   <= 1'b1;
            in_ready <= 1'b0;
        end
    end

    assign out_valid    = main_v;
    assign out_pc       = main_q.pc;
    assign out_imm_bits = main_q.instr[31:7];
    assign out_imm_type = main_q.imm_type;
    assign out_rd       = main_q.instr[11:7];
    assign out_rs1      = main_q.instr[19:15];
    assign out_rs2      = main_q.instr[24:20];
    assign out_funct3   = main_q.instr[14:12];
    assign out_funct7b5 = main_q.instr[30];
    assign out_opcode   = main_q.instr[6:0];
    assign out_illegal  = main_q.illegal;
endmodule
